imul_pipe: RTL and testbench
============================

Name: imul_pipe

Overview:
- Parametrised, fully pipelined integer multiply unit for the backend issue path.
- Executes RV32M MUL, MULH, MULHSU and MULHU with correct signed/unsigned handling for every type.
- Accepts one op per cycle and carries a ROB tag with each op.
- Provides valid/ready backpressure toward writeback and an optional flush for mispredict recovery.

Parameters:
- XLEN, 32, operand and result width.
- LATENCY, 5, accept-to-result cycles; legal range is LATENCY >= 2.
- TAG_WIDTH, 6, width of the tag carried with each op.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  op presented this cycle.
- in_ready  output  1  unit can accept an op this cycle.
- in_type  input  2  operation: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- in1  input  XLEN  rs1 operand.
- in2  input  XLEN  rs2 operand.
- in_tag  input  TAG_WIDTH  tag returned with the result.
- flush  input  1  kill all in-flight ops; only active with IMUL_FLUSH_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  XLEN  result.
- out_tag  output  TAG_WIDTH  tag of the result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out=0, out_tag=0, all stage valid bits=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation drops every in-flight op; no result for those ops ever appears.
- Handshake:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready.
- Stall = out_valid && !out_ready. in_ready = !stall, combinational.
- During a stall, all stages including out, out_tag and out_valid hold unchanged. No op is lost or duplicated.
- Latency: an op accepted at edge k produces out_valid=1 after edge k+LATENCY-1, i.e. visible LATENCY cycles after presentation, when there are no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one op per cycle. Results retire strictly in issue order.
- Arithmetic:
  - Extend both operands to XLEN+1 bits, signed.
  - in1 is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - in2 is sign-extended for MULH only, zero-extended otherwise.
  - Form the signed (2*XLEN+2)-bit product.
  - MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Pipeline structure:
  - The product is formed at the first stage.
  - in_type, or a derived high/low select bit, travels alongside the product through LATENCY-1 further registers.
  - Synthesis may retime across these registers.
- Bubbles: stages carry a per-stage valid bit. Bubbles propagate and are squeezed only through normal advance; there is no compaction.
- out and out_tag are don't-care while out_valid=0, except after reset, where both are 0.

Optional Feature:
- Macro: IMUL_FLUSH_EN.
- Defined:
  - flush=1 at an edge clears every stage valid bit and out_valid.
  - An op presented with in_valid in the same cycle is discarded.
  - flush overrides stall.
  - in_ready=1 in the cycle after flush.
- Undefined: the flush port is ignored; in-flight ops complete normally.

Test Plan:
- MUL directed: MUL in1=7, in2=0xFFFFFFFD, tag=0x11, out_ready=1 -> out_valid rises exactly 5 cycles later with out=0xFFFFFFEB, out_tag=0x11, and lasts one cycle.
- High-half types, one op each:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHSU 0x00000002*0x80000000 -> 0x00000001.
- Back-to-back: 5 ops on consecutive cycles (tags 1..5, MUL i*i) -> out_valid high 5 consecutive cycles starting 5 cycles after the first op, with out=1,4,9,16,25 in tag order.
- Backpressure: with a result pending, hold out_ready=0 for 3 cycles while presenting new ops -> in_ready=0, out and out_tag stable, no op accepted. After release, all results appear in order, each exactly once.
- Flush: 3 ops in flight, pulse flush with in_valid=1:
  - With IMUL_FLUSH_EN: out_valid=0 from the next cycle; none of the 4 results ever appear.
  - Without IMUL_FLUSH_EN: all 4 results appear.
- Reset: assert reset 2 cycles after issuing 2 ops -> out_valid=0, out=0, out_tag=0 after the edge; no stale result appears after reset deasserts.

Source files
------------

// File: rtl/imul_pipe.sv
// -----------------------------------------------------------------------------
// imul_pipe
//   Fully pipelined integer multiply unit for the backend issue path.
//   Executes RV32M MUL / MULH / MULHSU / MULHU and accepts one op per cycle.
//   Each op carries a ROB tag that is returned with its result. Results retire
//   strictly in issue order.
//
//   The full product is formed combinationally in front of the first pipeline
//   register. A high/low select bit travels with the product through LATENCY-1
//   further registers, so synthesis is free to retime the multiplier across
//   them. The last register holds the selected XLEN-bit result, which drives
//   out directly.
//
//   A result that is valid but not taken freezes the whole pipe (stall). There
//   is no bubble compaction: every stage advances or holds together.
//
// Parameters:
//   XLEN       operand and result width
//   LATENCY    accept-to-result cycles (>= 2)
//   TAG_WIDTH  width of the tag carried with each op
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   in_valid   op presented this cycle
//   in_ready   unit can accept an op this cycle (combinational, = !stall)
//   in_type    0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
//   in1, in2   rs1 / rs2 operands
//   in_tag     tag returned with the result
//   flush      kill every in-flight op (only with IMUL_FLUSH_EN)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out        result
//   out_tag    tag of the result
//
// Build option:
//   IMUL_FLUSH_EN  when defined, flush clears every stage valid bit and
//                  out_valid, and discards an op presented in the same cycle.
//                  When undefined, flush is ignored.
// -----------------------------------------------------------------------------
module imul_pipe #(
    parameter int XLEN      = 32,
    parameter int LATENCY   = 5,
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_type,
    input  logic [XLEN-1:0]      in1,
    input  logic [XLEN-1:0]      in2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int PW = 2 * XLEN;
    // Product-carrying stages; the output register is the final stage.
    localparam int NS = LATENCY - 1;

    logic                 stall;
    logic                 adv;
    logic                 kill;

    logic                 sign1;
    logic                 sign2;
    logic [XLEN:0]        op1_ext;
    logic [XLEN:0]        op2_ext;
    logic signed [PW+1:0] prod_full;
    logic [1:0]           prod_unused;

    logic [PW-1:0]        prod_q [NS];
    logic                 hi_q   [NS];
    logic [TAG_WIDTH-1:0] tag_q  [NS];
    logic                 vld_q  [NS];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign adv      = !stall;

`ifdef IMUL_FLUSH_EN
    assign kill = flush;
`else
    logic flush_unused;
    assign kill         = 1'b0;
    assign flush_unused = flush;
`endif

    // Operand extension to XLEN+1 bits: rs1 is signed for MULH/MULHSU,
    // rs2 only for MULH. The extra bit lets one signed multiplier cover all
    // four types, including unsigned operands with the MSB set.
    always_comb begin
        sign1     = (in_type == 2'd1) || (in_type == 2'd2);
        sign2     = (in_type == 2'd1);
        op1_ext   = {sign1 & in1[XLEN-1], in1};
        op2_ext   = {sign2 & in2[XLEN-1], in2};
        prod_full = $signed({{(XLEN + 1){op1_ext[XLEN]}}, op1_ext})
                  * $signed({{(XLEN + 1){op2_ext[XLEN]}}, op2_ext});
    end

    // The top two product bits never reach a result.
    assign prod_unused = prod_full[PW+1:PW];

    // Datapath registers carry no reset; only the valid bits and the visible
    // output need a defined value.
    always_ff @(posedge clock) begin
        if (adv) begin
            prod_q[0] <= prod_full[PW-1:0];
            hi_q[0]   <= (in_type != 2'd0);
            tag_q[0]  <= in_tag;
            for (int i = 1; i < NS; i++) begin
                prod_q[i] <= prod_q[i-1];
                hi_q[i]   <= hi_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                vld_q[i] <= 1'b0;
            end
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
        end else if (kill) begin
            // Flush wins over a stall and drops the op presented this cycle.
            for (int i = 0; i < NS; i++) begin
                vld_q[i] <= 1'b0;
            end
            out_valid <= 1'b0;
        end else if (adv) begin
            // adv implies in_ready, so in_valid alone marks an accepted op.
            vld_q[0] <= in_valid;
            for (int i = 1; i < NS; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            out_valid <= vld_q[NS-1];
            out       <= hi_q[NS-1] ? prod_q[NS-1][PW-1:XLEN]
                                    : prod_q[NS-1][XLEN-1:0];
            out_tag   <= tag_q[NS-1];
        end
    end

endmodule

// File: tb/tb_imul_pipe.sv
module tb_imul_pipe;

    localparam int XLEN = 32;
    localparam int LAT  = 5;
    localparam int TW   = 6;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_type = 2'd0;
    logic [XLEN-1:0] in1 = '0;
    logic [XLEN-1:0] in2 = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out;
    logic [TW-1:0]   out_tag;

    imul_pipe #(.XLEN(XLEN), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_type  (in_type),
        .in1      (in1),
        .in2      (in2),
        .in_tag   (in_tag),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_tag  (out_tag)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stall_total = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [TW-1:0]   tag;
        int              acc;
        int              snap;
    } exp_t;

    exp_t sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: true mathematical product of the extended operands.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] t, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        longint    sa;
        longint    sb_v;
        logic [63:0] p;
        sa   = (t == 2'd1 || t == 2'd2) ? longint'($signed(a)) : longint'(a);
        sb_v = (t == 2'd1) ? longint'($signed(b)) : longint'(b);
        p    = sa * sb_v;
        return (t == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Monitor: pops the scoreboard on every output transfer.
    // Latency rule: transfer edge - accept edge - stall edges in between == LAT.
    logic            prev_stall = 1'b0;
    logic [XLEN-1:0] prev_out;
    logic [TW-1:0]   prev_tag;

    always begin
        exp_t e;
        @(negedge clock);
        #1;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_out", out, prev_out);
                check("hold_tag", out_tag, prev_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual=%0h tag=%0h required=none (cycle %0d)",
                             out, out_tag, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", out, e.res);
                    check("tag", out_tag, e.tag);
                    check("latency", (cyc + 1 - e.acc) - (stall_total - e.snap), LAT);
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_total++;
            prev_out = out;
            prev_tag = out_tag;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue_exp(input logic [1:0] t, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [TW-1:0] tg, input logic [XLEN-1:0] res);
        in_valid = 1'b1;
        in_type  = t;
        in1      = a;
        in2      = b;
        in_tag   = tg;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back('{res, tg, cyc + 1, stall_total});
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout actual=no_accept required=accept tag=%0h", tg);
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TW-1:0] tg);
        issue_exp(t, a, b, tg, ref_mul(t, a, b));
    endtask

    task automatic wait_out_valid();
        for (int k = 0; k < 30; k++) begin
            if (out_valid) return;
            idle(1);
        end
        total++;
        bad++;
        $display("FAIL wait_out_valid actual=0 required=1");
    endtask

    function automatic logic [XLEN-1:0] rand_operand();
        logic [XLEN-1:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_out_tag", out_tag, 0);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        idle(1);

        // MUL directed
        issue_exp(2'd0, 32'd7, 32'hFFFF_FFFD, 6'h11, 32'hFFFF_FFEB);
        idle(8);

        // High-half types
        issue_exp(2'd1, 32'h8000_0000, 32'h8000_0000, 6'h21, 32'h4000_0000);
        issue_exp(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h22, 32'hFFFF_FFFE);
        issue_exp(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h23, 32'hFFFF_FFFF);
        issue_exp(2'd2, 32'h0000_0002, 32'h8000_0000, 6'h24, 32'h0000_0001);
        idle(8);

        // Back-to-back
        for (int i = 1; i <= 5; i++) begin
            issue_exp(2'd0, XLEN'(i), XLEN'(i), TW'(i), XLEN'(i * i));
        end
        idle(8);

        // Backpressure: hold out_ready low for 3 cycles while presenting ops
        for (int i = 0; i < 3; i++) begin
            issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), TW'(8 + i));
        end
        wait_out_valid();
        out_ready = 1'b0;
        fork
            begin
                idle(3);
                out_ready = 1'b1;
            end
            begin
                issue(2'd1, rand_operand(), rand_operand(), 6'h30);
                issue(2'd2, rand_operand(), rand_operand(), 6'h31);
            end
        join
        idle(10);

        // Flush with 3 ops in flight and a 4th presented alongside
        for (int i = 0; i < 3; i++) begin
            issue(2'($urandom_range(0, 3)), rand_operand(), rand_operand(), TW'(16 + i));
        end
        in_valid = 1'b1;
        in_type  = 2'd0;
        in1      = 32'd3;
        in2      = 32'd5;
        in_tag   = 6'h13;
        flush    = 1'b1;
        @(negedge clock);
`ifdef IMUL_FLUSH_EN
        sb.delete();
`else
        if (in_ready) begin
            sb.push_back('{32'd15, 6'h13, cyc + 1, stall_total});
        end else begin
            total++;
            bad++;
            $display("FAIL flush_accept actual=in_ready_0 required=in_ready_1");
        end
`endif
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
`ifdef IMUL_FLUSH_EN
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
`endif
        idle(15);
        check("flush_drain", sb.size(), 0);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = rand_operand();
            b = rand_operand();
            issue(2'($urandom_range(0, 3)), a, b, TW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(30);
        check("random_drain", sb.size(), 0);

        // Reset mid-operation
        issue(2'd0, 32'd6, 32'd7, 6'h2A);
        issue(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 6'h2B);
        idle(2);
        reset = 1'b1;
        @(negedge clock);
        sb.delete();
        @(posedge clock);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out", out, 0);
        check("midrst_out_tag", out_tag, 0);
        reset = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        idle(20);

        // One more op after reset to show the pipe still runs
        issue(2'd1, 32'hFFFF_FFF0, 32'h0000_0010, 6'h3F);
        idle(10);
        check("final_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
